pim_dma_ctrl: RTL and testbench

//  Sequences word transfers between data memory and one of four PIM macros for core DMA commands
//  (funct3/sel/size/addr issued from EX). Owns the shared dmem port mux between the core LSU and the DMA

---
 rtl/pim_dma_ctrl.sv | 138 +++++++++++++
 tb/tb_pim_dma_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_dma_ctrl.sv
// DMA sequencer that moves words between data memory and one of four PIM macros,
// and shares the single dmem port with the core LSU (core wins only while DMA is issuing).
module pim_dma_ctrl #(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dma_en_i,
  input  logic [2:0]        dma_funct3_i,
  input  logic [3:0]        dma_sel_pim_i,
  input  logic [12:0]       dma_size_i,
  input  logic [XLEN-1:0]   dma_mem_addr_i,
  output logic              dma_busy_o,
  output logic              dma_done_o,
  output logic              dma_err_o,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic [XLEN-1:0]   core_addr_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  input  logic [3:0]        core_size_i,
  input  logic              core_read_i,
  input  logic              core_write_i,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [3:0]        dmem_size_o,
  output logic              dmem_read_o,
  output logic              dmem_write_o,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [3:0]        pim_sel_o,
  output logic [PIM_AW-1:0] pim_addr_o,
  output logic [XLEN-1:0]   pim_wdata_o,
  output logic              pim_we_o,
  output logic              pim_re_o,
  input  logic [XLEN-1:0]   pim_rdata_i
);

  // state | meaning: IDLE wait cmd | ISSUE read source word | XFER write dest word | DONE pulse
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  localparam int NW = 11;

  state_t          state, state_nxt;
  logic            dir;
  logic [3:0]      sel;
  logic [XLEN-3:0] base;
  logic [NW-1:0]   nwords;
  logic [NW-1:0]   cnt;
  logic            err_q;

  logic            cmd_legal;
  logic            dma_rd, dma_wr, pim_we, pim_re, done;
  logic            dma_drive;
  logic [XLEN-1:0] dma_addr;
  logic            unused_bits;

  assign unused_bits = ^{dma_size_i[1:0], dma_mem_addr_i[1:0]};
  assign cmd_legal   = (dma_funct3_i[2:1] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      dir    <= 1'b0;
      sel    <= '0;
      base   <= '0;
      nwords <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= dma_en_i && ((state != IDLE) || !cmd_legal);
      if (state == IDLE && dma_en_i && cmd_legal) begin
        dir    <= dma_funct3_i[0];
        sel    <= dma_sel_pim_i;
        base   <= dma_mem_addr_i[XLEN-1:2];
        nwords <= dma_size_i[12:2];
        cnt    <= '0;
      end else if (state == XFER) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    dma_rd     = 1'b0;
    dma_wr     = 1'b0;
    pim_we     = 1'b0;
    pim_re     = 1'b0;
    done       = 1'b0;
    core_gnt_o = core_req_i && (state != XFER);
    case (state)
      IDLE: begin
        if (dma_en_i && cmd_legal)
          state_nxt = (dma_size_i[12:2] == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        // The core keeps priority here; the DMA just retries next cycle.
        if (!core_req_i) begin
          if (dir) pim_re = 1'b1;
          else     dma_rd = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (dir) dma_wr = 1'b1;
        else     pim_we = 1'b1;
        state_nxt = (cnt == nwords - 1'b1) ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by reset so an aborted job stops touching memory in the reset cycle.
  assign dma_addr  = {base, 2'b00} + XLEN'({cnt, 2'b00});
  assign dma_drive = (dma_rd || dma_wr) && !rst_i;

  assign dmem_addr_o  = dma_drive ? dma_addr    : core_addr_i;
  assign dmem_wdata_o = dma_drive ? pim_rdata_i : core_wdata_i;
  assign dmem_size_o  = dma_drive ? 4'b1111     : core_size_i;
  assign dmem_read_o  = dma_drive ? dma_rd      : core_read_i;
  assign dmem_write_o = dma_drive ? dma_wr      : core_write_i;

  assign pim_we_o    = pim_we && !rst_i;
  assign pim_re_o    = pim_re && !rst_i;
  assign pim_addr_o  = (pim_we_o || pim_re_o) ? PIM_AW'(cnt) : '0;
  assign pim_wdata_o = pim_we_o ? dmem_rdata_i : '0;
  assign pim_sel_o   = (state != IDLE) ? sel : 4'b0000;

  assign dma_busy_o = (state != IDLE);
  assign dma_done_o = done && !rst_i;
  assign dma_err_o  = err_q && !rst_i;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Bench for pim_dma_ctrl: a per-job schedule of expected word operations is compared
// every cycle against the DUT, plus directed jobs with hand-computed literal results.
module tb_pim_dma_ctrl;
  localparam int XLEN = 32;
  localparam int PIM_AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, dma_en_i, dma_busy_o, dma_done_o, dma_err_o;
  logic [2:0] dma_funct3_i;
  logic [3:0] dma_sel_pim_i;
  logic [12:0] dma_size_i;
  logic [31:0] dma_mem_addr_i;
  logic core_req_i, core_gnt_o, core_read_i, core_write_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [3:0] core_size_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0] dmem_size_o;
  logic dmem_read_o, dmem_write_o;
  logic [3:0] pim_sel_o;
  logic [PIM_AW-1:0] pim_addr_o;
  logic [31:0] pim_wdata_o, pim_rdata_i;
  logic pim_we_o, pim_re_o;

  pim_dma_ctrl #(.XLEN(XLEN), .PIM_AW(PIM_AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i), .dma_sel_pim_i(dma_sel_pim_i),
    .dma_size_i(dma_size_i), .dma_mem_addr_i(dma_mem_addr_i),
    .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_size_i(core_size_i),
    .core_read_i(core_read_i), .core_write_i(core_write_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_size_o(dmem_size_o),
    .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o), .dmem_rdata_i(dmem_rdata_i),
    .pim_sel_o(pim_sel_o), .pim_addr_o(pim_addr_o), .pim_wdata_o(pim_wdata_o),
    .pim_we_o(pim_we_o), .pim_re_o(pim_re_o), .pim_rdata_i(pim_rdata_i)
  );

  // Memory contents are pure functions of address, so expected data needs no storage.
  function automatic logic [31:0] fmem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  function automatic logic [31:0] fpim(input logic [PIM_AW-1:0] a);
    return ({21'd0, a} * 32'h0100_0193) ^ 32'h5A5A_1234;
  endfunction

  typedef enum int {OP_ISSUE, OP_XFER, OP_DONE} op_kind_e;
  typedef struct { op_kind_e kind; int k; } op_t;
  op_t q[$];

  logic        m_dir;
  logic [3:0]  m_sel;
  logic [31:0] m_base;
  logic        err_pend = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  logic rand_core = 1'b1;
  logic last_rd = 1'b0, last_re = 1'b0;
  logic [31:0] last_rd_addr = '0;
  logic [PIM_AW-1:0] last_re_addr = '0;

  logic [31:0] obs_rd[$], obs_wr_addr[$], obs_wr_data[$];
  int obs_pw[$];
  int done_at, err_at, busy_cnt, gnt_cnt, done_cnt, err_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_obs();
    obs_rd.delete(); obs_wr_addr.delete(); obs_wr_data.delete(); obs_pw.delete();
    done_at = -1; err_at = -1; busy_cnt = 0; gnt_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic step(input logic en, input logic [2:0] f3, input logic [3:0] sel,
                      input logic [12:0] size, input logic [31:0] addr,
                      input logic req, input logic rst);
    logic busy_m, consume, chk_wd;
    logic ex_gnt, ex_rd, ex_wr, ex_we, ex_re, ex_done;
    logic [31:0] ex_addr, ex_wdata, ex_pwdata;
    logic [3:0] ex_size;
    int ex_paddr, nw;
    op_t h;
    dma_en_i = en; dma_funct3_i = f3; dma_sel_pim_i = sel; dma_size_i = size;
    dma_mem_addr_i = addr; core_req_i = req; rst_i = rst;
    core_addr_i = $urandom; core_wdata_i = $urandom; core_size_i = 4'($urandom);
    core_read_i = rand_core ? 1'($urandom) : 1'b0;
    core_write_i = rand_core ? 1'($urandom) : 1'b0;
    dmem_rdata_i = last_rd ? fmem(last_rd_addr) : $urandom;
    pim_rdata_i = last_re ? fpim(last_re_addr) : $urandom;
    #2;
    busy_m = (q.size() != 0);
    consume = 1'b0;
    if (rst) begin
      chk("rst_done", dma_done_o, 1'b0);
      chk("rst_err", dma_err_o, 1'b0);
      chk("rst_pim_we", pim_we_o, 1'b0);
      chk("rst_pim_re", pim_re_o, 1'b0);
      chk("rst_dmem_read", dmem_read_o, core_read_i);
      chk("rst_dmem_write", dmem_write_o, core_write_i);
      chk("rst_dmem_addr", dmem_addr_o, core_addr_i);
    end else begin
      ex_gnt = req; ex_rd = core_read_i; ex_wr = core_write_i; ex_addr = core_addr_i;
      ex_size = core_size_i; ex_wdata = core_wdata_i; chk_wd = 1'b1;
      ex_we = 1'b0; ex_re = 1'b0; ex_done = 1'b0; ex_paddr = 0; ex_pwdata = '0;
      if (busy_m) begin
        h = q[0];
        case (h.kind)
          OP_ISSUE: if (!req) begin
            consume = 1'b1;
            if (!m_dir) begin
              ex_rd = 1'b1; ex_wr = 1'b0; ex_size = 4'hF; chk_wd = 1'b0;
              ex_addr = m_base + 32'(4 * h.k);
            end else begin
              ex_re = 1'b1; ex_paddr = h.k % (1 << PIM_AW);
            end
          end
          OP_XFER: begin
            consume = 1'b1; ex_gnt = 1'b0;
            if (!m_dir) begin
              ex_we = 1'b1; ex_paddr = h.k % (1 << PIM_AW);
              ex_pwdata = fmem(m_base + 32'(4 * h.k));
            end else begin
              ex_rd = 1'b0; ex_wr = 1'b1; ex_size = 4'hF;
              ex_addr = m_base + 32'(4 * h.k);
              ex_wdata = fpim(PIM_AW'(h.k));
            end
          end
          default: begin consume = 1'b1; ex_done = 1'b1; end
        endcase
      end
      chk("busy", dma_busy_o, busy_m);
      chk("done", dma_done_o, ex_done);
      chk("err", dma_err_o, err_pend);
      chk("core_gnt", core_gnt_o, ex_gnt);
      chk("pim_sel", pim_sel_o, busy_m ? m_sel : 4'b0000);
      chk("dmem_read", dmem_read_o, ex_rd);
      chk("dmem_write", dmem_write_o, ex_wr);
      chk("dmem_addr", dmem_addr_o, ex_addr);
      chk("dmem_size", dmem_size_o, ex_size);
      if (chk_wd) chk("dmem_wdata", dmem_wdata_o, ex_wdata);
      chk("pim_we", pim_we_o, ex_we);
      chk("pim_re", pim_re_o, ex_re);
      if (ex_we || ex_re) chk("pim_addr", 32'(pim_addr_o), 32'(ex_paddr));
      if (ex_we) chk("pim_wdata", pim_wdata_o, ex_pwdata);
    end
    if (!rand_core && dmem_read_o) obs_rd.push_back(dmem_addr_o);
    if (!rand_core && dmem_write_o) begin
      obs_wr_addr.push_back(dmem_addr_o); obs_wr_data.push_back(dmem_wdata_o);
    end
    if (pim_we_o) obs_pw.push_back(int'(pim_addr_o));
    if (dma_done_o) begin done_cnt++; done_at = cyc; end
    if (dma_err_o) begin err_cnt++; err_at = cyc; end
    if (dma_busy_o) busy_cnt++;
    if (core_gnt_o) gnt_cnt++;
    last_rd = dmem_read_o; last_rd_addr = dmem_addr_o;
    last_re = pim_re_o; last_re_addr = pim_addr_o;
    if (rst) begin
      q.delete(); err_pend = 1'b0;
    end else begin
      if (consume) void'(q.pop_front());
      err_pend = en && (busy_m || (f3 > 3'd1));
      if (en && !busy_m && (f3 <= 3'd1)) begin
        m_dir = f3[0]; m_sel = sel; m_base = {addr[31:2], 2'b00};
        nw = int'(size[12:2]);
        for (int k = 0; k < nw; k++) begin
          q.push_back('{OP_ISSUE, k}); q.push_back('{OP_XFER, k});
        end
        q.push_back('{OP_DONE, 0});
      end
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input int n, input logic req);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 13'd0, 32'd0, req, 1'b0);
  endtask

  int c0;

  initial begin
    clr_obs();
    @(posedge clk); #1;
    step(1'b0, 3'd0, 4'd0, 13'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 4'd0, 13'd0, 32'd0, 1'b0, 1'b1);
    chk("reset_busy", dma_busy_o, 1'b0);
    chk("reset_sel", pim_sel_o, 4'b0000);
    chk("reset_done", dma_done_o, 1'b0);

    rand_core = 1'b0;
    // 4-word mem->PIM from 0x100
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b000, 4'b0010, 13'd16, 32'h100, 1'b0, 1'b0);
    idle(12, 1'b0);
    chk("m2p_done_at", 32'(done_at - c0), 32'd9);
    chk("m2p_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("m2p_nreads", 32'(obs_rd.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_rd.size(); i++) chk("m2p_rd_addr", obs_rd[i], 32'h100 + 32'(4 * i));
    chk("m2p_npw", 32'(obs_pw.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_pw.size(); i++) chk("m2p_pw_idx", 32'(obs_pw[i]), 32'(i));

    // 2-word PIM->mem from unaligned 0x203
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b001, 4'b0100, 13'd8, 32'h203, 1'b0, 1'b0);
    idle(8, 1'b0);
    chk("p2m_done_at", 32'(done_at - c0), 32'd5);
    chk("p2m_nwrites", 32'(obs_wr_addr.size()), 32'd2);
    if (obs_wr_addr.size() == 2) begin
      chk("p2m_wr_addr0", obs_wr_addr[0], 32'h200);
      chk("p2m_wr_addr1", obs_wr_addr[1], 32'h204);
      chk("p2m_wr_data0", obs_wr_data[0], fpim(11'd0));
      chk("p2m_wr_data1", obs_wr_data[1], fpim(11'd1));
    end

    // zero-word job
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b000, 4'b0001, 13'd3, 32'h80, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("zero_done_at", 32'(done_at - c0), 32'd1);
    chk("zero_busy_cycles", 32'(busy_cnt), 32'd1);
    chk("zero_strobes", 32'(obs_rd.size() + obs_wr_addr.size() + obs_pw.size()), 32'd0);

    // core holds the port for 3 cycles while DMA is in ISSUE
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b000, 4'b1000, 13'd8, 32'h40, 1'b0, 1'b0);
    idle(3, 1'b1);
    idle(8, 1'b0);
    chk("stall_gnt_cycles", 32'(gnt_cnt), 32'd3);
    chk("stall_done_at", 32'(done_at - c0), 32'd8);
    chk("stall_npw", 32'(obs_pw.size()), 32'd2);

    // illegal funct3
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b010, 4'b0001, 13'd16, 32'h0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("illegal_err_at", 32'(err_at - c0), 32'd1);
    chk("illegal_err_cnt", 32'(err_cnt), 32'd1);
    chk("illegal_busy", 32'(busy_cnt), 32'd0);

    // command while busy
    clr_obs(); c0 = cyc;
    step(1'b1, 3'b000, 4'b0010, 13'd16, 32'h100, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 3'b001, 4'b0001, 13'd4, 32'h500, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("busy_cmd_err_cnt", 32'(err_cnt), 32'd1);
    chk("busy_cmd_err_at", 32'(err_at - c0), 32'd5);
    chk("busy_cmd_done_at", 32'(done_at - c0), 32'd9);
    chk("busy_cmd_npw", 32'(obs_pw.size()), 32'd4);

    // reset during XFER of a 4-word job
    clr_obs();
    step(1'b1, 3'b000, 4'b0010, 13'd16, 32'h300, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 3'd0, 4'd0, 13'd0, 32'd0, 1'b0, 1'b1);
    chk("abort_busy", dma_busy_o, 1'b0);
    clr_obs();
    idle(12, 1'b0);
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    chk("abort_busy_cycles", 32'(busy_cnt), 32'd0);
    chk("abort_npw", 32'(obs_pw.size()), 32'd0);

    // randomized traffic against the schedule model
    rand_core = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 8) == 0,
           (($urandom % 4) == 0) ? 3'($urandom) : {2'b00, 1'($urandom)},
           4'b0001 << ($urandom % 4),
           (($urandom % 10) == 0) ? 13'($urandom % 200) : 13'($urandom % 48),
           (($urandom % 4) == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom,
           ($urandom % 4) == 0,
           ($urandom % 300) == 0);
    end
    idle(220, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
